pipe_rca_adder: RTL and testbench
=================================

# pipe_rca_adder

Parametrised, pipelined ripple-carry adder/subtractor for WIDTH-bit operands, split into STAGES equal carry chunks with the inter-chunk carry registered. It extends the team's combinational ripple-carry adders to arbitrary width, adds a subtract mode and a signed-overflow flag, and gives a valid/ready stream interface with full backpressure. It sits in arithmetic datapaths where a full-width combinational carry chain would miss timing.

## Interface
- WIDTH, 8, operand/result width; must be a multiple of STAGES
- STAGES, 4, pipeline stages; CHUNK = WIDTH/STAGES bits per stage; STAGES ≥ 1
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operand beat valid
- in_ready  out  1  block accepts a beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- sub  in  1  0: a+b, 1: a−b (computed as a + ~b + 1)
- out_valid  out  1  result beat valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  result, modulo 2^WIDTH
- carry  out  1  carry out of MSB (in subtract mode 1 = no borrow)
- overflow  out  1  two's-complement overflow: carry into MSB XOR carry out of MSB

## Operation
- Stage k (0..STAGES−1) adds bits [k·CHUNK +: CHUNK] of a and (b XOR {WIDTH{sub}}) plus the carry registered from stage k−1. Stage 0 carry-in is sub.
- Operand bits not yet consumed are skewed forward through registers alongside the carry. Completed sum chunks are deskewed, so all sum bits of a beat appear together.
- Global advance = !out_valid || out_ready. When advance is 1, every stage register and valid bit shifts one stage. When it is 0, all pipeline state holds.
- in_ready = advance && !rst. A beat is accepted when in_valid && in_ready.
- A bubble (in_valid = 0 while advancing) propagates as an invalid slot. Stages carrying invalid slots still shift.
- sum, carry and overflow are registered outputs. They are stable and unchanged while out_valid && !out_ready.
- overflow is computed in the last stage from the carry into and out of bit WIDTH−1. It is valid for both add and sub.
- Results emerge in acceptance order. There is no reordering and no dropping.

## Timing
- Latency: a beat accepted at edge t gives out_valid = 1 after edge t+STAGES, given no stall. Each stall cycle adds 1.
- Throughput: 1 beat/cycle with out_ready held at 1.
- Reset: while rst = 1, all valid bits, sum, carry, overflow and internal carries are cleared to 0, and in_ready = 0. out_valid = 0 from the first edge with rst = 1.
- Reset mid-operation: all in-flight beats are discarded, with no partial output. The first accept is possible in the first cycle rst = 0.
- Simultaneous output pop and input accept in one cycle is legal. The pipe stays full and no beat is lost.
- Full pipe with out_ready = 0: in_ready = 0 in the same cycle, combinationally.
- STAGES = 1: a single registered full-width adder with latency 1.
- Wrap-around: sums exceeding 2^WIDTH−1 wrap. The lost bit is reported on carry.

## Structure
- Shared arithmetic package: the width-derivation constant CHUNK and a compile-time check that WIDTH % STAGES == 0 and STAGES ≥ 1.
- Sub-module rca_chunk: combinational CHUNK-bit ripple-carry adder built from full-adder cells. Inputs: x, y, cin. Outputs: s, cout, and c_msb_in (the carry into its top bit, needed by the last stage for overflow). Instantiate it STAGES times in a generate loop.
- Top level holds the skew/deskew register arrays, the valid shift chain and the advance logic.

## Test plan
- WIDTH=8, STAGES=4, add 8'h7F + 8'h01 → after 4 cycles, one beat: sum 8'h80, carry 0, overflow 1.
- Add 8'hFF + 8'h01 → sum 8'h00, carry 1, overflow 0. Then 2'b01 + 2'b11 zero-extended → sum 8'h04, carry 0.
- Sub 8'h05 − 8'h07 → sum 8'hFE, carry 0, overflow 0. Then sub 8'h80 − 8'h01 → sum 8'h7F, carry 1, overflow 1.
- Stream 8 back-to-back beats a=i, b=2i with out_ready = 1 → 8 consecutive results 3i, latency 4. Next, drop out_ready for 3 cycles mid-stream → in_ready = 0 and outputs hold while stalled, with no beat lost or duplicated.
- Fill 3 beats, then assert rst for 1 cycle → out_valid stays 0 and none of those beats ever appear. The next beat after reset gives the correct result 4 cycles later.
- Parameter sweep WIDTH=16/STAGES=1, WIDTH=16/STAGES=16, WIDTH=32/STAGES=4 with random operands, sub and out_ready → all results match a reference model (sum, carry, overflow) and preserve order.

Source files
------------

// File: rtl/pipe_rca_adder_pkg.sv
// Shared arithmetic helpers for the pipelined ripple-carry adder:
// chunk sizing, parameter legality and the full-adder cell.
package pipe_rca_adder_pkg;

  function automatic int chunk_width(input int width, input int stages);
    return (stages > 0) ? (width / stages) : width;
  endfunction

  function automatic bit params_ok(input int width, input int stages);
    return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
  endfunction

  // Returns {carry_out, sum} of one full-adder cell.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

endpackage

// File: rtl/pipe_rca_adder_rca_chunk.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
// Also exposes the carry into its top bit so the last stage can flag overflow.
module rca_chunk
  import pipe_rca_adder_pkg::*;
#(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  // Ripple the carry bit by bit through the cell chain.
  always_comb begin
    logic       cc;
    logic [1:0] fa;
    s        = '0;
    c_msb_in = cin;
    cc       = cin;
    fa       = 2'b00;
    for (int i = 0; i < CHUNK; i++) begin
      c_msb_in = cc;
      fa       = full_add(x[i], y[i], cc);
      s[i]     = fa[0];
      cc       = fa[1];
    end
    cout = cc;
  end

endmodule

// File: rtl/pipe_rca_adder.sv
// Pipelined ripple-carry adder/subtractor: STAGES carry chunks with the
// inter-chunk carry registered, operand skew, sum deskew and valid/ready flow.
module pipe_rca_adder
  import pipe_rca_adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("pipe_rca_adder: WIDTH must be a nonzero multiple of STAGES");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             msb_cin [STAGES];

  assign b_eff    = b ^ {WIDTH{sub}};
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !rst;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CHUNK;
    localparam int HI = LO + CHUNK;

    // a_in/b_in hold only the operand bits this stage and later ones consume.
    logic [WIDTH-LO-1:0] a_in;
    logic [WIDTH-LO-1:0] b_in;
    logic                cin;
    logic                vin;
    logic [HI-1:0]       sum_next;
    logic [CHUNK-1:0]    s;
    logic                cout;
    logic                v_r;
    logic                c_r;
    logic [HI-1:0]       sum_r;

    if (k == 0) begin : g_head
      assign a_in     = a;
      assign b_in     = b_eff;
      assign cin      = sub;
      assign vin      = in_valid;
      assign sum_next = s;
    end else begin : g_body
      assign a_in     = g_stage[k-1].g_fwd.a_r;
      assign b_in     = g_stage[k-1].g_fwd.b_r;
      assign cin      = g_stage[k-1].c_r;
      assign vin      = g_stage[k-1].v_r;
      assign sum_next = {s, g_stage[k-1].sum_r};
    end

    rca_chunk #(.CHUNK(CHUNK)) u_chunk (
      .x        (a_in[CHUNK-1:0]),
      .y        (b_in[CHUNK-1:0]),
      .cin      (cin),
      .s        (s),
      .cout     (cout),
      .c_msb_in (msb_cin[k])
    );

    // Stage valid, registered carry and completed low sum bits.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_r   <= 1'b0;
        c_r   <= 1'b0;
        sum_r <= '0;
      end else if (advance) begin
        v_r   <= vin;
        c_r   <= cout;
        sum_r <= sum_next;
      end
    end

    if (k < STAGES - 1) begin : g_fwd
      logic [WIDTH-HI-1:0] a_r;
      logic [WIDTH-HI-1:0] b_r;

      // Skew the not-yet-consumed operand bits forward with the carry.
      always_ff @(posedge clk) begin
        if (rst) begin
          a_r <= '0;
          b_r <= '0;
        end else if (advance) begin
          a_r <= a_in[WIDTH-LO-1:CHUNK];
          b_r <= b_in[WIDTH-LO-1:CHUNK];
        end
      end
    end else begin : g_tail
      logic ovf_r;

      // Signed overflow: carry into the MSB differs from carry out of it.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_r <= 1'b0;
        end else if (advance) begin
          ovf_r <= cout ^ msb_cin[k];
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_r;
  assign sum       = g_stage[STAGES-1].sum_r;
  assign carry     = g_stage[STAGES-1].c_r;
  assign overflow  = g_stage[STAGES-1].g_tail.ovf_r;

endmodule

// File: tb/tb_pipe_rca_adder.sv
// Scoreboard bench: directed vectors on an 8/4 instance plus randomised
// streams on 16/1, 16/16 and 32/4 instances checked against a reference model.
module tb_pipe_rca_adder;

  typedef struct packed {
    logic [31:0] sum;
    logic        carry;
    logic        ovf;
    logic        chk_lat;
    int          cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw_rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       sub;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       carry;
  logic       overflow;

  int   n_pass  = 0;
  int   n_total = 0;
  int   cyc     = 0;
  exp_t q[$];

  logic       hold_v = 1'b0;
  logic [9:0] hold_val = 10'd0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  pipe_rca_adder #(.WIDTH(8), .STAGES(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry     (carry),
    .overflow  (overflow)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
    n_total++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, expv, cyc);
  endtask

  task automatic fail(input string name, input string what);
    n_total++;
    $display("FAIL %s: %s at cycle %0d", name, what, cyc);
  endtask

  // Reference: {ovf, carry, sum} from plain wide arithmetic and sign rules.
  function automatic logic [33:0] model(input int w, input logic [31:0] x,
                                        input logic [31:0] y, input logic s);
    logic [31:0] mask, xx, yy, r;
    logic [32:0] full;
    logic        c, o;
    mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    xx   = x & mask;
    yy   = (s ? ~y : y) & mask;
    full = {1'b0, xx} + {1'b0, yy} + {32'd0, s};
    c    = full[w];
    r    = full[31:0] & mask;
    o    = (xx[w-1] == yy[w-1]) && (r[w-1] != xx[w-1]);
    return {o, c, r};
  endfunction

  task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                      input logic [7:0] es, input logic ec, input logic eo,
                      input logic lat);
    int waited;
    exp_t e;
    waited   = 0;
    in_valid = 1'b1;
    a        = ta;
    b        = tb;
    sub      = ts;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        e = '{sum: {24'd0, es}, carry: ec, ovf: eo, chk_lat: lat, cyc: cyc};
        q.push_back(e);
        break;
      end
      waited++;
      if (waited > 50) begin
        fail("accept", "in_ready timeout");
        break;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (q.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (q.size() != 0) fail(name, "drain timeout");
    @(posedge clk); #1;
  endtask

  // Main monitor: pops on handshake, checks hold and in_ready while stalled.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      hold_v <= 1'b0;
    end else begin
      if (hold_v)
        chk("stall_hold", 64'({out_valid, sum, carry, overflow}), 64'({1'b1, hold_val}));
      if (out_valid && !out_ready) begin
        chk("in_ready_stalled", 64'(in_ready), 64'(0));
        hold_v   <= 1'b1;
        hold_val <= {sum, carry, overflow};
      end else begin
        hold_v <= 1'b0;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          fail("unexpected_beat", "output with empty scoreboard");
        end else begin
          e = q.pop_front();
          chk("sum", 64'(sum), 64'(e.sum));
          chk("carry", 64'(carry), 64'(e.carry));
          chk("overflow", 64'(overflow), 64'(e.ovf));
          if (e.chk_lat) chk("latency", 64'(cyc), 64'(e.cyc + 4));
        end
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int W  = (g == 2) ? 32 : 16;
    localparam int S  = (g == 0) ? 1 : ((g == 1) ? 16 : 4);
    localparam int NB = 150;

    logic [W-1:0] sa, sb, ssum;
    logic         siv, sir, ssub, sov, sor, sc, so;
    logic         taken;
    bit           done;
    int           sent;
    exp_t         sq[$];

    pipe_rca_adder #(.WIDTH(W), .STAGES(S)) u_sw (
      .clk       (clk),
      .rst       (sw_rst),
      .in_valid  (siv),
      .in_ready  (sir),
      .a         (sa),
      .b         (sb),
      .sub       (ssub),
      .out_valid (sov),
      .out_ready (sor),
      .sum       (ssum),
      .carry     (sc),
      .overflow  (so)
    );

    initial begin : drv
      logic [31:0] r1, r2;
      logic [33:0] m;
      exp_t        e;
      siv = 1'b0; sa = '0; sb = '0; ssub = 1'b0; sor = 1'b0;
      taken = 1'b0; sent = 0; done = 1'b0;
      wait (sw_rst == 1'b0);
      @(posedge clk); #1;
      for (int t = 0; t < 4000 && sent < NB; t++) begin
        if (taken || !siv) begin
          siv  = ($urandom_range(0, 3) != 0);
          r1   = $urandom();
          r2   = $urandom();
          sa   = r1[W-1:0];
          sb   = r2[W-1:0];
          ssub = ($urandom_range(0, 1) == 1);
        end
        sor = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        taken = siv && sir;
        if (taken) begin
          m = model(W, 32'(sa), 32'(sb), ssub);
          e = '{sum: m[31:0], carry: m[32], ovf: m[33], chk_lat: 1'b0, cyc: cyc};
          sq.push_back(e);
          sent++;
        end
        @(posedge clk); #1;
      end
      if (sent < NB) fail("sw_stream", "too few beats accepted");
      siv = 1'b0;
      sor = 1'b1;
      for (int t = 0; t < 100 && sq.size() != 0; t++) @(posedge clk);
      chk("sw_drain", 64'(sq.size()), 64'(0));
      done = 1'b1;
    end

    // Sweep monitor: order and value check against the model.
    always @(negedge clk) begin : sw_mon
      exp_t e;
      if (!sw_rst && sov && sor) begin
        if (sq.size() == 0) begin
          fail("sw_unexpected", "output with empty scoreboard");
        end else begin
          e = sq.pop_front();
          chk("sw_sum", 64'(ssum), 64'(e.sum));
          chk("sw_carry", 64'(sc), 64'(e.carry));
          chk("sw_overflow", 64'(so), 64'(e.ovf));
        end
      end
    end
  end

  initial begin : stim
    rst = 1'b1; sw_rst = 1'b1;
    in_valid = 1'b0; a = 8'h00; b = 8'h00; sub = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_in_ready", 64'(in_ready), 64'(0));
    chk("reset_sum", 64'(sum), 64'(0));
    chk("reset_carry", 64'(carry), 64'(0));
    chk("reset_overflow", 64'(overflow), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0; sw_rst = 1'b0;

    // Directed add/sub vectors with hand-computed results.
    send(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
    send(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    send(8'h01, 8'h03, 1'b0, 8'h04, 1'b0, 1'b0, 1'b1);
    send(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1);
    send(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b1);
    send(8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    send(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    send(8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1, 1'b1);
    drain("drain_directed");

    for (int i = 0; i < 8; i++)
      send(8'(i), 8'(2 * i), 1'b0, 8'(3 * i), 1'b0, 1'b0, 1'b1);
    drain("drain_stream");

    fork
      for (int i = 8; i < 16; i++)
        send(8'(i), 8'(2 * i), 1'b0, 8'(3 * i), 1'b0, 1'b0, 1'b0);
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("drain_stall");

    send(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0);
    send(8'h11, 8'h21, 1'b0, 8'h32, 1'b0, 1'b0, 1'b0);
    send(8'h12, 8'h22, 1'b0, 8'h34, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("in_ready_in_reset", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    chk("out_valid_after_reset", 64'(out_valid), 64'(0));
    chk("in_ready_after_reset", 64'(in_ready), 64'(1));
    @(posedge clk); #1;
    send(8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
    drain("drain_reset");
    repeat (6) @(posedge clk);

    for (int t = 0; t < 20000 &&
         !(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done); t++)
      @(posedge clk);
    if (!(g_sweep[0].done && g_sweep[1].done && g_sweep[2].done))
      fail("sweep_done", "sweep did not finish");
    chk("main_queue_empty", 64'(q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
